ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter that shares the single-port 128x16 data RAM between two requesters: m0 (CPU data port) and m1 (program loader / DMA).
- Accepts a req/ack transaction from each requester, grants one at a time, and drives the RAM's load/address/input pins.
- Captures read data after a fixed RAM read latency and returns it with a one-cycle ack pulse.
- Sits between the requesters and the ram instance in the Hack platform top level.

Parameters:
- ADDR_W, 7, RAM address width (128 words).
- DATA_W, 16, RAM word width.
- RD_LAT, 1, clock cycles from address presented (load=0) until ram_output is valid; legal range 1..4.
- FIXED_PRI, 0, 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- m0_req / m1_req  in  1  transaction request; held with its fields until ack.
- m0_load / m1_load  in  1  1 = write, 0 = read.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_input / m1_input  in  DATA_W  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_output / m1_output  out  DATA_W  read data, registered.
- ram_load  out  1  RAM write enable.
- ram_address  out  ADDR_W  RAM address.
- ram_input  out  DATA_W  RAM write data.
- ram_output  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  requester currently served; holds its last value when IDLE.

Behaviour:
- Reset (reset_n low at a posedge) forces, from the next cycle:
  - state IDLE;
  - ram_load, ram_address, ram_input, acks, m0_output, m1_output, busy, grant_id all 0;
  - round-robin pointer favours m0.
- States: IDLE -> ISSUE -> (write) ACK -> IDLE; (read) WAIT -> ACK -> IDLE.
- IDLE, arbitration at a posedge:
  - Only one req high: that requester is granted.
  - Both high, FIXED_PRI=0: the pointer's master wins; the pointer then moves to the other master.
  - Both high, FIXED_PRI=1: m0 wins.
  - After every grant the pointer points to the non-granted master.
- ISSUE (1 cycle):
  - ram_address and ram_input take the granted master's fields.
  - ram_load = granted load.
  - Fields are latched internally at grant; later input changes are ignored.
- Write: ram_load high only during ISSUE; ACK follows. Ack is visible 2 cycles after the req-sampling edge.
- Read:
  - ram_load stays 0; address held through WAIT, which lasts RD_LAT cycles.
  - ram_output is registered into mX_output at the edge ending WAIT.
  - ACK then follows; ack is visible RD_LAT+2 cycles after the sampling edge.
- ram_address holds its value from ISSUE through ACK and keeps the last value in IDLE. ram_load is 0 in every state except write ISSUE.
- ACK (1 cycle):
  - Only the granted master's ack is high; state -> IDLE.
  - The requester deasserts req at the edge where it samples ack. A req still high in IDLE is a new transaction. Minimum spacing between transactions is therefore 1 IDLE cycle.
- mX_output changes only on that master's own read capture; writes and the other master's reads leave it unchanged.
- Req dropped before ack (protocol violation): the transaction completes and ack still pulses.
- Reset mid-transaction: next state IDLE and ram_load 0; no ack is issued. A write already issued in ISSUE may have landed in RAM.
- Addresses are all valid (2^ADDR_W words); no range check.

Decomposition:
- Shared include hack_defs.vh holds:
  - ADDR_W and DATA_W defaults;
  - state encodings ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_ACK=3.
- One sub-module, rr_pick2: combinational two-way picker. Inputs req[1:0], ptr, fixed_pri; outputs grant_valid, grant_id.
- Pointer register and FSM stay in ram_arbiter.

Test Plan:
- Reset: hold reset_n=0 3 cycles with both reqs high -> all outputs 0, no ack, busy=0. Release -> m0 granted first.
- m0 write addr 5 data 57 -> ram_load=1 for exactly one cycle with ram_address=5, ram_input=57. m0_ack 2 cycles after the sampling edge. m1_ack never asserted.
- m1 read addr 5 after the above, RD_LAT=1 and RD_LAT=3 -> m1_output=57 at m1_ack (cycles 3 / 5 after sampling). m0_output unchanged.
- Both reqs held high for 4 transactions, FIXED_PRI=0 -> grant order m0,m1,m0,m1; each ack pulses once. With FIXED_PRI=1 -> m0,m0,m0,m0 while m1 starves.
- reset_n low during WAIT of a read -> no ack, IDLE next cycle, m0_output unchanged. A subsequent read of the same address completes normally.
- m0 drops req in ISSUE of a write to addr 9 data 0xBEEF -> write still lands (read back 0xBEEF) and m0_ack still pulses once.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-port data-RAM arbiter.
// The state encodings match the platform's historical IDLE/ISSUE/WAIT/ACK numbering.
package ram_arbiter_pkg;

  localparam int unsigned AddrWDef = 7;
  localparam int unsigned DataWDef = 16;
  localparam int unsigned CntW     = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } state_e;

  // One-hot ack vector for the served requester: bit 0 = m0, bit 1 = m1.
  function automatic logic [1:0] ack_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side req/ack channel into the RAM arbiter.
// The master is the requester and the slave is the arbiter.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = AddrWDef,
  parameter int unsigned DataW = DataWDef
) ();

  logic             req;
  logic             load;
  logic [AddrW-1:0] address;
  logic [DataW-1:0] wdata;
  logic             ack;
  logic [DataW-1:0] rdata;

  modport master (output req, load, address, wdata, input ack, rdata);
  modport slave  (input req, load, address, wdata, output ack, rdata);

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin by pointer, or m0-first when fixed_pri_i is set.
module ram_arbiter_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       fixed_pri_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_id_o = fixed_pri_i ? 1'b0 : ptr_i;
    end else begin
      grant_id_o = req_i[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (m0) and the loader/DMA (m1).
// One transaction at a time; read data is captured RdLat cycles after the address is issued.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AddrW    = AddrWDef,
  parameter int unsigned DataW    = DataWDef,
  parameter int unsigned RdLat    = 1,
  parameter bit          FixedPri = 1'b0
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  ram_arbiter_if.slave     m0_io,
  ram_arbiter_if.slave     m1_io,
  output logic             ram_load_o,
  output logic [AddrW-1:0] ram_address_o,
  output logic [DataW-1:0] ram_input_o,
  input  logic [DataW-1:0] ram_output_i,
  output logic             busy_o,
  output logic             grant_id_o
);

  state_e           state_q;
  logic             ptr_q;
  logic             gid_q;
  logic             load_lat_q;
  logic             ram_load_q;
  logic [AddrW-1:0] ram_address_q;
  logic [DataW-1:0] ram_input_q;
  logic [CntW-1:0]  cnt_q;
  logic [1:0]       ack_q;
  logic [DataW-1:0] out0_q;
  logic [DataW-1:0] out1_q;
  logic             busy_q;

  logic             pick_valid;
  logic             pick_id;
  logic             pick_load;
  logic [AddrW-1:0] pick_addr;
  logic [DataW-1:0] pick_wdata;

  ram_arbiter_rr_pick2 u_pick (
    .req_i         ({m1_io.req, m0_io.req}),
    .ptr_i         (ptr_q),
    .fixed_pri_i   (FixedPri),
    .grant_valid_o (pick_valid),
    .grant_id_o    (pick_id)
  );

  always_comb begin
    pick_load  = pick_id ? m1_io.load    : m0_io.load;
    pick_addr  = pick_id ? m1_io.address : m0_io.address;
    pick_wdata = pick_id ? m1_io.wdata   : m0_io.wdata;
  end

  // Single FSM; every output is a register so the RAM pins never glitch on requester inputs.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      gid_q         <= 1'b0;
      load_lat_q    <= 1'b0;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
      ram_input_q   <= '0;
      cnt_q         <= '0;
      ack_q         <= 2'b00;
      out0_q        <= '0;
      out1_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      ack_q      <= 2'b00;
      ram_load_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q       <= StIssue;
            busy_q        <= 1'b1;
            gid_q         <= pick_id;
            ptr_q         <= ~pick_id;
            load_lat_q    <= pick_load;
            ram_load_q    <= pick_load;
            ram_address_q <= pick_addr;
            ram_input_q   <= pick_wdata;
          end
        end
        StIssue: begin
          cnt_q <= CntW'(RdLat - 1);
          if (load_lat_q) begin
            state_q <= StAck;
            ack_q   <= ack_onehot(gid_q);
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (gid_q) begin
              out1_q <= ram_output_i;
            end else begin
              out0_q <= ram_output_i;
            end
            ack_q   <= ack_onehot(gid_q);
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StAck: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_load_o    = ram_load_q;
  assign ram_address_o = ram_address_q;
  assign ram_input_o   = ram_input_q;
  assign busy_o        = busy_q;
  assign grant_id_o    = gid_q;
  assign m0_io.ack     = ack_q[0];
  assign m1_io.ack     = ack_q[1];
  assign m0_io.rdata   = out0_q;
  assign m1_io.rdata   = out1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: DUT A (RdLat=1, round-robin) and DUT B (RdLat=3, fixed priority),
// each with its own RAM model; sel routes the shared requester stimulus to one of them.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   sel;

  logic          m0_req, m0_load, m1_req, m1_load;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  ram_arbiter_if #(.AddrW(AW), .DataW(DW)) a_m0 ();
  ram_arbiter_if #(.AddrW(AW), .DataW(DW)) a_m1 ();
  ram_arbiter_if #(.AddrW(AW), .DataW(DW)) b_m0 ();
  ram_arbiter_if #(.AddrW(AW), .DataW(DW)) b_m1 ();

  assign a_m0.req = m0_req & (sel == 0);
  assign a_m0.load = m0_load;
  assign a_m0.address = m0_addr;
  assign a_m0.wdata = m0_wdata;
  assign a_m1.req = m1_req & (sel == 0);
  assign a_m1.load = m1_load;
  assign a_m1.address = m1_addr;
  assign a_m1.wdata = m1_wdata;
  assign b_m0.req = m0_req & (sel == 1);
  assign b_m0.load = m0_load;
  assign b_m0.address = m0_addr;
  assign b_m0.wdata = m0_wdata;
  assign b_m1.req = m1_req & (sel == 1);
  assign b_m1.load = m1_load;
  assign b_m1.address = m1_addr;
  assign b_m1.wdata = m1_wdata;

  logic          a_ram_load, b_ram_load, a_busy, b_busy, a_gid, b_gid;
  logic [AW-1:0] a_ram_addr, b_ram_addr;
  logic [DW-1:0] a_ram_in, b_ram_in, a_ram_out, b_ram_out;

  ram_arbiter #(.AddrW(AW), .DataW(DW), .RdLat(1), .FixedPri(1'b0)) u_dut_a (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .m0_io         (a_m0),
    .m1_io         (a_m1),
    .ram_load_o    (a_ram_load),
    .ram_address_o (a_ram_addr),
    .ram_input_o   (a_ram_in),
    .ram_output_i  (a_ram_out),
    .busy_o        (a_busy),
    .grant_id_o    (a_gid)
  );

  ram_arbiter #(.AddrW(AW), .DataW(DW), .RdLat(3), .FixedPri(1'b1)) u_dut_b (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .m0_io         (b_m0),
    .m1_io         (b_m1),
    .ram_load_o    (b_ram_load),
    .ram_address_o (b_ram_addr),
    .ram_input_o   (b_ram_in),
    .ram_output_i  (b_ram_out),
    .busy_o        (b_busy),
    .grant_id_o    (b_gid)
  );

  // RAM models: registered read, latency 1 (A) and 3 (B).
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];

  always @(posedge clk) begin
    if (a_ram_load) mem_a[a_ram_addr] <= a_ram_in;
    pipe_a <= mem_a[a_ram_addr];
    if (b_ram_load) mem_b[b_ram_addr] <= b_ram_in;
    pipe_b[0] <= mem_b[b_ram_addr];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign a_ram_out = pipe_a;
  assign b_ram_out = pipe_b[2];

  logic          o_ack0, o_ack1, o_ram_load, o_busy, o_gid;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_in, o_out0, o_out1;

  always_comb begin
    if (sel == 0) begin
      o_ack0 = a_m0.ack; o_ack1 = a_m1.ack; o_out0 = a_m0.rdata; o_out1 = a_m1.rdata;
      o_ram_load = a_ram_load; o_ram_addr = a_ram_addr; o_ram_in = a_ram_in;
      o_busy = a_busy; o_gid = a_gid;
    end else begin
      o_ack0 = b_m0.ack; o_ack1 = b_m1.ack; o_out0 = b_m0.rdata; o_out1 = b_m1.rdata;
      o_ram_load = b_ram_load; o_ram_addr = b_ram_addr; o_ram_in = b_ram_in;
      o_busy = b_busy; o_gid = b_gid;
    end
  end

  typedef struct packed {
    logic          id;
    logic          is_rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [2][1<<AW];
  logic [DW-1:0] exp_out [2][2];
  int            n_chk;
  int            n_fail;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic rq, input logic ld,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin
      m1_req = rq; m1_load = ld; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = rq; m0_load = ld; m0_addr = a; m0_wdata = d;
    end
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 20) begin
      tick();
      cyc++;
      if (o_ack0) who = 0;
      else if (o_ack1) who = 1;
    end
  endtask

  // One complete transaction from an idle DUT, checked against the scoreboard entry it pushes.
  task automatic txn(input logic id, input logic ld, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int exp_lat, input bit drop_early,
                     input string tag);
    exp_t          e;
    int            lat, loads, stray;
    bit            got;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data, obs, oth;
    e.id = id;
    e.is_rd = ~ld;
    e.data = ld ? d : ref_mem[sel][a];
    sb.push_back(e);
    if (ld) ref_mem[sel][a] = d;
    drive(id, 1'b1, ld, a, d);
    lat = 0; loads = 0; stray = 0; got = 1'b0; ld_addr = '0; ld_data = '0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (drop_early && lat == 1) drive(id, 1'b0, ld, a, d);
      if (o_ram_load) begin
        loads++; ld_addr = o_ram_addr; ld_data = o_ram_in;
      end
      if (id ? o_ack0 : o_ack1) stray++;
      if (id ? o_ack1 : o_ack0) got = 1'b1;
    end
    drive(id, 1'b0, ld, a, d);
    e = sb.pop_front();
    n_chk++;
    if (!got || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s ack latency: got %0d (acked=%0b), expected %0d", tag, lat, got, exp_lat);
    end
    n_chk++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL %s other ack: got %0d pulses, expected 0", tag, stray);
    end
    if (e.is_rd) begin
      obs = e.id ? o_out1 : o_out0;
      n_chk++;
      if (obs !== e.data) begin
        n_fail++;
        $display("FAIL %s read data: got %h, expected %h", tag, obs, e.data);
      end
      exp_out[sel][e.id] = e.data;
      n_chk++;
      if (loads != 0) begin
        n_fail++;
        $display("FAIL %s ram_load during read: got %0d cycles, expected 0", tag, loads);
      end
    end else begin
      n_chk++;
      if (loads != 1 || ld_addr !== a || ld_data !== d) begin
        n_fail++;
        $display("FAIL %s write issue: got %0d loads addr %0d data %h, expected 1 addr %0d data %h",
                 tag, loads, ld_addr, ld_data, a, d);
      end
      obs = e.id ? o_out1 : o_out0;
      n_chk++;
      if (obs !== exp_out[sel][e.id]) begin
        n_fail++;
        $display("FAIL %s own output after write: got %h, expected %h", tag, obs,
                 exp_out[sel][e.id]);
      end
    end
    oth = e.id ? o_out0 : o_out1;
    n_chk++;
    if (oth !== exp_out[sel][!e.id]) begin
      n_fail++;
      $display("FAIL %s other output: got %h, expected %h", tag, oth, exp_out[sel][!e.id]);
    end
    tick();
    n_chk++;
    if (o_ack0 || o_ack1 || o_busy) begin
      n_fail++;
      $display("FAIL %s after ack: got ack0=%0b ack1=%0b busy=%0b, expected 0 0 0",
               tag, o_ack0, o_ack1, o_busy);
    end
  endtask

  task automatic test_reset();
    int   who, cyc;
    exp_t e;
    sel = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 7'd100, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 7'd101, 16'h2222);
    repeat (3) begin
      tick();
      n_chk++;
      if ({o_ack0, o_ack1, o_busy, o_gid, o_ram_load} !== 5'b0 || o_ram_addr !== '0 ||
          o_ram_in !== '0 || o_out0 !== '0 || o_out1 !== '0) begin
        n_fail++;
        $display("FAIL reset state: got ack=%b%b busy=%b gid=%b load=%b addr=%0d in=%h o0=%h o1=%h, expected all 0",
                 o_ack1, o_ack0, o_busy, o_gid, o_ram_load, o_ram_addr, o_ram_in, o_out0, o_out1);
      end
    end
    rst_n = 1'b1;
    ref_mem[0][100] = 16'h1111;
    ref_mem[0][101] = 16'h2222;
    e = '{id: 1'b0, is_rd: 1'b0, data: 16'h1111};
    sb.push_back(e);
    e = '{id: 1'b1, is_rd: 1'b0, data: 16'h2222};
    sb.push_back(e);
    tick();
    n_chk++;
    if (o_busy !== 1'b1 || o_gid !== 1'b0 || o_ram_addr !== 7'd100) begin
      n_fail++;
      $display("FAIL reset first grant: got busy=%b gid=%b addr=%0d, expected 1 0 100",
               o_busy, o_gid, o_ram_addr);
    end
    for (int k = 0; k < 2; k++) begin
      wait_ack(who, cyc);
      e = sb.pop_front();
      n_chk++;
      if (who != int'(e.id)) begin
        n_fail++;
        $display("FAIL reset grant order %0d: got %0d, expected %0d", k, who, e.id);
      end
      drive(e.id, 1'b0, 1'b1, 7'd0, 16'h0);
    end
    tick();
  endtask

  task automatic test_arb(input bit fixed, input string tag);
    int   who, cyc;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.id = fixed ? 1'b0 : 1'(k % 2);
      e.is_rd = 1'b0;
      e.data = '0;
      sb.push_back(e);
    end
    ref_mem[sel][20] = 16'hA0A0;
    ref_mem[sel][21] = 16'hB1B1;
    drive(1'b0, 1'b1, 1'b1, 7'd20, 16'hA0A0);
    drive(1'b1, 1'b1, 1'b1, 7'd21, 16'hB1B1);
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, cyc);
      e = sb.pop_front();
      n_chk++;
      if (who != int'(e.id) || cyc != (k == 0 ? 2 : 3) || o_gid !== e.id) begin
        n_fail++;
        $display("FAIL %s grant %0d: got id %0d after %0d cycles gid=%b, expected id %0d after %0d",
                 tag, k, who, cyc, o_gid, e.id, (k == 0 ? 2 : 3));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 7'd20, 16'hA0A0);
    if (fixed) begin
      wait_ack(who, cyc);
      n_chk++;
      if (who != 1 || cyc != 3) begin
        n_fail++;
        $display("FAIL %s starved m1 drain: got id %0d after %0d cycles, expected id 1 after 3",
                 tag, who, cyc);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 7'd21, 16'hB1B1);
    tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    sel = 1;
    drive(1'b0, 1'b1, 1'b0, 7'd5, 16'h0);
    repeat (3) tick();
    n_chk++;
    if (o_busy !== 1'b1 || o_ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid pre: got busy=%b ack0=%b, expected 1 0", o_busy, o_ack0);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 7'd5, 16'h0);
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) exp_out[s][m] = '0;
    end
    n_chk++;
    if (o_busy !== 1'b0 || o_ram_load !== 1'b0 || o_ack0 !== 1'b0 || o_out0 !== exp_out[1][0]) begin
      n_fail++;
      $display("FAIL reset_mid state: got busy=%b load=%b ack0=%b out0=%h, expected 0 0 0 %h",
               o_busy, o_ram_load, o_ack0, o_out0, exp_out[1][0]);
    end
    acks = 0;
    repeat (6) begin
      tick();
      if (o_ack0 || o_ack1) acks++;
    end
    n_chk++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_mid stray ack: got %0d pulses, expected 0", acks);
    end
    txn(1'b0, 1'b0, 7'd5, 16'h0, 5, 1'b0, "reset_mid reread");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    sel = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) exp_out[s][m] = '0;
    end

    test_reset();
    // DUT A: RdLat=1, round-robin
    txn(1'b0, 1'b1, 7'd5, 16'd57, 2, 1'b0, "write_a");
    txn(1'b1, 1'b0, 7'd5, 16'h0, 3, 1'b0, "read_lat1");
    test_arb(1'b0, "round_robin");
    txn(1'b0, 1'b1, 7'd9, 16'hBEEF, 2, 1'b1, "drop_req write");
    txn(1'b1, 1'b0, 7'd9, 16'h0, 3, 1'b0, "drop_req readback");
    // DUT B: RdLat=3, fixed priority
    sel = 1;
    txn(1'b0, 1'b1, 7'd5, 16'd57, 2, 1'b0, "write_b");
    txn(1'b1, 1'b0, 7'd5, 16'h0, 5, 1'b0, "read_lat3");
    test_arb(1'b1, "fixed_pri");
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
